// File: rtl/noc_tx_pkg.sv
// Shared register-map constants for the NoC transmit port FIFO.
// Every file that touches the CSR map imports these definitions.
package noc_tx_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLR    = 2'd3;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CLR_OVF    = 0;

  // One-hot write strobes decoded from a single bus access.
  typedef struct packed {
    logic wr_data;
    logic wr_ctrl;
    logic wr_clr;
  } csr_wr_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO with push/pop/flush and occupancy outputs.
// The head word is presented combinationally; it reads as zero when empty.
module noc_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Flush voids both operations; a full FIFO still accepts a word when it pops.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/noc_tx_port_fifo.sv
// Avalon-MM slave that queues Nios words and drains them onto a NoC stream.
// Holds the CSRs, sticky overflow, last-pushed shadow and the read mux.
module noc_tx_port_fifo
  import noc_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  csr_wr_t           wr_s;
  logic              wr;
  logic              push;
  logic              pop;
  logic              flush;
  logic              drop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  logic              enable_q, enable_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] last_pushed_q, last_pushed_d;

  assign wr = chipselect & ~write_n;

  always_comb begin
    wr_s         = '0;
    wr_s.wr_data = wr & (address == ADDR_DATA);
    wr_s.wr_ctrl = wr & (address == ADDR_CTRL);
    wr_s.wr_clr  = wr & (address == ADDR_CLR);
  end

  // Stream handshake: a word moves on any cycle with out_valid and out_ready high.
  // out_valid depends only on registered state, never on out_ready.
  assign out_valid = enable_q & ~empty;
  assign pop       = out_valid & out_ready;
  assign flush     = wr_s.wr_ctrl & writedata[CTRL_FLUSH];
  assign push      = wr_s.wr_data & (~full | pop) & ~flush;
  assign drop      = wr_s.wr_data & full & ~pop & ~flush;

  always_comb begin
    enable_d      = enable_q;
    overflow_d    = overflow_q;
    last_pushed_d = last_pushed_q;
    if (wr_s.wr_ctrl) enable_d = writedata[CTRL_EN];
    if (push) last_pushed_d = writedata[DATA_W-1:0];
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) overflow_d = 1'b1;
    else if (wr_s.wr_clr && writedata[CLR_OVF]) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b1;
      overflow_q    <= 1'b0;
      last_pushed_q <= '0;
    end else begin
      enable_q      <= enable_d;
      overflow_q    <= overflow_d;
      last_pushed_q <= last_pushed_d;
    end
  end

  noc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (writedata[DATA_W-1:0]),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_W-1:0] = last_pushed_q;
      ADDR_STATUS: begin
        readdata[CNT_W-1:0] = count;
        readdata[ST_EMPTY]  = empty;
        readdata[ST_FULL]   = full;
        readdata[ST_OVF]    = overflow_q;
      end
      ADDR_CTRL: readdata[CTRL_EN] = enable_q;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_noc_tx_port_fifo.sv
// Directed bench for noc_tx_port_fifo: CSR map, fill/drain order, overflow,
// pass-through when full, enable hold, flush and mid-drain reset.
module tb_noc_tx_port_fifo;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  noc_tx_port_fifo #(.DATA_W(32), .DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(addr, v);
    check(tag, v, exp);
  endtask

  // Pop n words with out_ready held high, comparing against the scoreboard.
  task automatic drain(input string tag, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
      else check({tag, "_data"}, out_data, exp_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_reg("rst_status", 2'd1, 32'h0001_0000);
    check_reg("rst_ctrl", 2'd2, 32'h0000_0001);
    check_reg("rst_data", 2'd0, 32'h0000_0000);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_odata", out_data, 32'd0);

    // Fill to full; head visible one cycle after the first write
    for (int i = 1; i <= 8; i++) begin
      bus_write(2'd0, 32'hA5A5_0000 + i);
      exp_q.push_back(32'hA5A5_0000 + i);
      if (i == 1) begin
        #1;
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_odata", out_data, 32'hA5A5_0001);
      end
    end
    check_reg("full_status", 2'd1, 32'h0002_0008);
    bus_write(2'd0, 32'hDEAD_BEEF);
    check_reg("ovf_status", 2'd1, 32'h0006_0008);
    check_reg("ovf_lastpushed", 2'd0, 32'hA5A5_0008);

    @(negedge clk);
    drain("drain1", 8);
    #1;
    check("drain1_empty_valid", {31'd0, out_valid}, 32'd0);
    check_reg("drain1_status", 2'd1, 32'h0005_0000);

    // Clear with bit0=0 does nothing, bit0=1 clears
    bus_write(2'd3, 32'h0000_0002);
    check_reg("clr0_status", 2'd1, 32'h0005_0000);
    bus_write(2'd3, 32'h0000_0001);
    check_reg("clr1_status", 2'd1, 32'h0001_0000);
    check_reg("clr_reads0", 2'd3, 32'h0000_0000);

    // Pass-through: write while full and popping
    for (int i = 0; i < 8; i++) begin
      bus_write(2'd0, 32'hB000_0000 + i);
      exp_q.push_back(32'hB000_0000 + i);
    end
    @(negedge clk);
    out_ready  = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd0;
    writedata  = 32'h1234_5678;
    #1;
    check("pt_head", out_data, exp_q.pop_front());
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_ready  = 1'b0;
    check_reg("pt_status", 2'd1, 32'h0002_0008);
    check_reg("pt_lastpushed", 2'd0, 32'h1234_5678);
    @(negedge clk);
    drain("drain2", 8);
    check_reg("drain2_status", 2'd1, 32'h0001_0000);

    // Enable hold
    bus_write(2'd2, 32'h0000_0000);
    for (int i = 1; i <= 3; i++) begin
      bus_write(2'd0, 32'hC000_0000 + i);
      exp_q.push_back(32'hC000_0000 + i);
    end
    out_ready = 1'b1;
    #1;
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check_reg("hold_status", 2'd1, 32'h0000_0003);
    check_reg("hold_ctrl", 2'd2, 32'h0000_0000);
    out_ready = 1'b0;
    bus_write(2'd2, 32'h0000_0001);
    drain("drain3", 3);
    check_reg("drain3_status", 2'd1, 32'h0001_0000);

    // Flush with five queued words
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'hE000_0000 + i);
    check_reg("preflush_status", 2'd1, 32'h0000_0005);
    bus_write(2'd2, 32'h0000_0003);
    out_ready = 1'b1;
    #1;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_odata", out_data, 32'd0);
    check_reg("flush_status", 2'd1, 32'h0001_0000);
    check_reg("flush_ctrl", 2'd2, 32'h0000_0001);
    out_ready = 1'b0;
    bus_write(2'd0, 32'hF00D_0001);
    exp_q.push_back(32'hF00D_0001);
    drain("postflush", 1);

    // Overflow, clear, overflow again, then reset mid-drain with enable low
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'hD000_0000 + i);
    bus_write(2'd0, 32'h0BAD_0BAD);
    check_reg("ovf2_status", 2'd1, 32'h0006_0008);
    bus_write(2'd3, 32'h0000_0001);
    check_reg("ovf2_clr_status", 2'd1, 32'h0002_0008);
    bus_write(2'd0, 32'h0BAD_0BAD);
    check_reg("ovf3_status", 2'd1, 32'h0006_0008);
    exp_q.push_back(32'hD000_0000);
    exp_q.push_back(32'hD000_0001);
    @(negedge clk);
    drain("middrain", 2);
    bus_write(2'd2, 32'h0000_0000);
    check_reg("middrain_status", 2'd1, 32'h0004_0006);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reg("rst2_status", 2'd1, 32'h0001_0000);
    check_reg("rst2_ctrl", 2'd2, 32'h0000_0001);
    check_reg("rst2_data", 2'd0, 32'h0000_0000);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_odata", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_write(2'd0, 32'h5555_AAAA);
    exp_q.push_back(32'h5555_AAAA);
    drain("postrst", 1);
    check("sb_leftover", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
